// File: rtl/dateline_vc_allocator.sv
// Dateline-aware virtual-channel allocator: each output port picks a downstream VC
// from the set chosen by the dateline crossing and keeps it for the whole packet.
module dateline_vc_allocator #(
    parameter int PORT_NUM = 6,
    parameter int VC_NUM   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PORT_NUM-1:0]        port_valid,
    input  logic [2*PORT_NUM-1:0]      flit_type,
    input  logic [PORT_NUM-1:0]        vc_in_set,
    input  logic [PORT_NUM-1:0]        cross_dateline,
    input  logic [PORT_NUM*VC_NUM-1:0] idle,
    input  logic [PORT_NUM*VC_NUM-1:0] full,
    output logic [PORT_NUM*VC_NUM-1:0] grant,
    output logic [PORT_NUM-1:0]        stall,
    output logic [PORT_NUM-1:0]        busy,
    output logic [PORT_NUM-1:0]        proto_err
);
    localparam int HALF  = VC_NUM / 2;
    localparam int PTR_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int VC_W  = $clog2(VC_NUM);

    localparam logic [1:0] FT_HEAD   = 2'b00;
    localparam logic [1:0] FT_TAIL   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

    genvar gi;
    generate
        for (gi = 0; gi < PORT_NUM; gi++) begin : g_port
            state_t            state_reg;
            logic [VC_W-1:0]   held_vc_reg;
            logic [PTR_W-1:0]  rr_ptr_reg;
            logic              proto_err_reg;

            logic [1:0]        ft;
            logic [VC_NUM-1:0] idle_p;
            logic [VC_NUM-1:0] full_p;
            logic [VC_NUM-1:0] grant_p;
            logic [HALF-1:0]   cand;
            logic              tset;
            logic              is_alloc;
            logic              found;
            logic              stall_p;
            logic [PTR_W-1:0]  pick_off;
            logic [VC_W-1:0]   pick_vc;

            assign ft       = flit_type[2*gi +: 2];
            assign idle_p   = idle[gi*VC_NUM +: VC_NUM];
            assign full_p   = full[gi*VC_NUM +: VC_NUM];
            assign tset     = vc_in_set[gi] ^ cross_dateline[gi];
            assign is_alloc = (ft == FT_HEAD) || (ft == FT_SINGLE);
            assign cand     = tset ? (idle_p[VC_NUM-1:HALF] & ~full_p[VC_NUM-1:HALF])
                                   : (idle_p[HALF-1:0] & ~full_p[HALF-1:0]);
            assign pick_vc  = VC_W'(tset ? HALF : 0) + VC_W'(pick_off);

            // Circular search inside the target set, starting at the round-robin pointer.
            always_comb begin
                found    = 1'b0;
                pick_off = '0;
                for (int k = 0; k < HALF; k++) begin
                    if (!found && cand[(int'(rr_ptr_reg) + k) % HALF]) begin
                        found    = 1'b1;
                        pick_off = PTR_W'((int'(rr_ptr_reg) + k) % HALF);
                    end
                end
            end

            always_comb begin
                grant_p = '0;
                stall_p = 1'b0;
                if (!rst && port_valid[gi]) begin
                    if (state_reg == S_IDLE) begin
                        if (is_alloc) begin
                            if (found)
                                grant_p[pick_vc] = 1'b1;
                            else
                                stall_p = 1'b1;
                        end
                    end else begin
                        // Any flit in HOLD rides the pinned VC, even a stray head.
                        grant_p[held_vc_reg] = 1'b1;
                        stall_p              = full_p[held_vc_reg];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg     <= S_IDLE;
                    held_vc_reg   <= '0;
                    rr_ptr_reg    <= '0;
                    proto_err_reg <= 1'b0;
                end else if (port_valid[gi]) begin
                    case (state_reg)
                        S_IDLE: begin
                            if (is_alloc) begin
                                if (found) begin
                                    rr_ptr_reg <= PTR_W'((int'(pick_off) + 1) % HALF);
                                    if (ft == FT_HEAD) begin
                                        state_reg   <= S_HOLD;
                                        held_vc_reg <= pick_vc;
                                    end
                                end
                            end else begin
                                proto_err_reg <= 1'b1;
                            end
                        end
                        default: begin
                            if (is_alloc)
                                proto_err_reg <= 1'b1;
                            if (ft == FT_TAIL && !full_p[held_vc_reg])
                                state_reg <= S_IDLE;
                        end
                    endcase
                end
            end

            assign grant[gi*VC_NUM +: VC_NUM] = grant_p;
            assign stall[gi]                  = stall_p;
            assign busy[gi]                   = (state_reg == S_HOLD);
            assign proto_err[gi]              = proto_err_reg;
        end
    endgenerate
endmodule

// File: doc/dateline_vc_allocator.md
DATELINE_VC_ALLOCATOR -- requirements
Module: dateline_vc_allocator

Interface
REQ-001 SHALL have parameter PORT_NUM, default 6, number of output ports (xpos,ypos,zpos,xneg,yneg,zneg = bits 0..5).
REQ-002 SHALL have parameter VC_NUM, default 4, VCs per port; even, >=2; set 0 = VCs [VC_NUM/2-1:0], set 1 = VCs [VC_NUM-1:VC_NUM/2].
REQ-003 SHALL have: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have: port_valid  input  PORT_NUM  flit requesting port p this cycle.
REQ-006 SHALL have: flit_type  input  2*PORT_NUM  per port: 00 head, 01 body, 10 tail, 11 single.
REQ-007 SHALL have: vc_in_set  input  PORT_NUM  VC set the packet currently occupies.
REQ-008 SHALL have: cross_dateline  input  PORT_NUM  hop on port p crosses the dimension dateline.
REQ-009 SHALL have: idle  input  PORT_NUM*VC_NUM  downstream VC free of any packet; port p at [p*VC_NUM +: VC_NUM].
REQ-010 SHALL have: full  input  PORT_NUM*VC_NUM  downstream VC buffer full, same packing.
REQ-011 SHALL have: grant  output  PORT_NUM*VC_NUM  one-hot (or zero) VC grant per port.
REQ-012 SHALL have: stall  output  PORT_NUM  flit on port p not accepted this cycle.
REQ-013 SHALL have: busy  output  PORT_NUM  port p holds a VC for an open multi-flit packet.
REQ-014 SHALL have: proto_err  output  PORT_NUM  sticky protocol-error flag per port.

Function
REQ-015 SHALL operate each port independently with a 2-state FSM: IDLE, HOLD; registers per port: state, held_vc, rr_ptr (log2(VC_NUM/2) bits), proto_err.
REQ-016 SHALL compute target set = vc_in_set XOR cross_dateline per port.
REQ-017 SHALL form candidates = idle & ~full restricted to target-set half.
REQ-018 In IDLE with valid head/single: grant = first candidate at or after rr_ptr (circular within set), same cycle (combinational, zero latency); stall=0.
REQ-019 In IDLE with valid head/single and no candidate: grant=0, stall=1, no state change.
REQ-020 On accepted head: next state HOLD, held_vc <= granted VC index (0..VC_NUM-1); on accepted single: remain IDLE.
REQ-021 On accepted head/single: rr_ptr <= (granted offset within set + 1) mod VC_NUM/2.
REQ-022 In HOLD with valid body/tail: grant = one-hot held_vc; stall = full[held_vc]; grant asserted even when stalled.
REQ-023 In HOLD, accepted tail (stall=0) returns to IDLE next cycle; stalled tail stays HOLD.
REQ-024 In IDLE, valid body/tail: grant=0, stall=0 (flit discarded), proto_err set.
REQ-025 In HOLD, valid head/single: treated as body (held_vc, no reallocation), proto_err set.
REQ-026 port_valid=0: grant=0, stall=0, no state change.
REQ-027 busy SHALL equal (state==HOLD), registered.
REQ-028 proto_err SHALL remain set until rst.
REQ-029 idle/full of a held VC SHALL not release HOLD; only an accepted tail does.

Reset
REQ-030 rst=1 at a rising edge: state IDLE, held_vc 0, rr_ptr 0, proto_err 0, for all ports, including mid-packet.
REQ-031 While rst=1, grant=0 and stall=0 regardless of inputs; busy=0 from the cycle after the reset edge.

Verification
REQ-032 VC_NUM=4, port0 single, vc_in_set=0, cross=1, idle=4'b1111, full=0 -> grant[3:0]=4'b0100, rr_ptr=1; repeat -> 4'b1000, then 4'b0100 (wrap).
REQ-033 Port3 head, vc_in_set=1, cross=0, idle=4'b0011 -> stall=1, grant=0; set idle=4'b1100 next cycle -> grant=4'b0100, busy=1 next cycle.
REQ-034 Port1 head,body,body,tail with full[held]=1 during 2nd body -> stall=1 that cycle, grant held; tail accepted -> busy=0 next cycle.
REQ-035 Port2 body in IDLE -> grant=0, stall=0, proto_err[2]=1 persisting until rst.
REQ-036 All six ports issue head same cycle, distinct sets -> six independent correct grants; rst asserted mid-packet -> busy=0, proto_err=0, next head grants from rr_ptr 0.
